// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types for the RAM arbiter and its lane unit
package ram_arbiter_pkg;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_ILL} size_e;
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, ERR} state_e;
  typedef enum logic {FETCH, DATA} grant_e;
endpackage

// File: rtl/ram_lane_unit.sv
// ram_lane_unit: load lane extraction/extension and store lane merge
module ram_lane_unit
  import ram_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] new_word
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  logic [31:0] mask;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    rdata = size == SIZE_B ? {{24{b[7] & ~uns}}, b} :
            size == SIZE_H ? {{16{h[15] & ~uns}}, h} : word;
    sh = size == SIZE_B ? {lane, 3'b000} : {lane[1], 4'b0000};
    mask = (size == SIZE_B ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    new_word = size == SIZE_W ? wdata : (old_word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of a word-wide RAM between fetch and load/store
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_unsigned,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        d_resp_err,
  output logic [31:0] ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);
  state_e      state, state_n;
  grant_e      last_grant;
  size_e       size_q, d_size;
  logic        fetch_q, we_q, uns_q;
  logic [31:0] addr_q, wdata_q, merge_q, ext, merged, req_addr;
  logic        gnt_fetch, i_hs, d_hs, hs, req_err, done;

  ram_lane_unit u_lane (
    .word(ram_data_out), .lane(addr_q[1:0]), .size(size_q), .uns(uns_q), .rdata(ext),
    .old_word(merge_q), .wdata(wdata_q), .new_word(merged)
  );

  always_comb begin
    d_size = size_e'(d_req_size);
    gnt_fetch = i_req_valid && (!d_req_valid || last_grant == DATA);
    i_hs = i_req_valid && i_req_ready;
    d_hs = d_req_valid && d_req_ready;
    hs = i_hs || d_hs;
    req_addr = i_hs ? i_req_addr : d_req_addr;
    req_err = req_addr >= 32'(MEM_SIZE) ||
              (i_hs ? req_addr[1:0] != 2'b00 :
               d_size == SIZE_ILL || (d_size == SIZE_H && req_addr[0]) ||
               (d_size == SIZE_W && req_addr[1:0] != 2'b00));
    done = state inside {ACCESS, RMW_WR, ERR};
  end

  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  // Sub-word stores need a read cycle first because the RAM only writes whole words
  always_comb begin
    state_n = state == IDLE ? (!hs ? IDLE : req_err ? ERR :
                               (d_hs && d_req_we && d_size != SIZE_W) ? RMW_RD : ACCESS) :
              state == RMW_RD ? RMW_WR : IDLE;
  end

  always_comb begin
    i_req_ready = !rst && state == IDLE && gnt_fetch;
    d_req_ready = !rst && state == IDLE && d_req_valid && !gnt_fetch;
    ram_addr = state inside {ACCESS, RMW_RD, RMW_WR} ? {addr_q[31:2], 2'b00} : '0;
    ram_we = !rst && (state == RMW_WR || (state == ACCESS && we_q));
    ram_data_in = ram_we ? merged : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= DATA;
      fetch_q <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= SIZE_W;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      i_resp_valid <= 1'b0;
      i_resp_data <= '0;
      i_resp_err <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_rdata <= '0;
      d_resp_err <= 1'b0;
    end else begin
      if (hs) begin
        last_grant <= i_hs ? FETCH : DATA;
        fetch_q <= i_hs;
        we_q <= !i_hs && d_req_we;
        uns_q <= i_hs || d_req_unsigned;
        size_q <= i_hs ? SIZE_W : d_size;
        addr_q <= req_addr;
        wdata_q <= d_req_wdata;
      end
      if (state == RMW_RD) merge_q <= ram_data_out;
      i_resp_valid <= done && fetch_q;
      i_resp_err <= state == ERR && fetch_q;
      i_resp_data <= state == ACCESS && fetch_q ? ext : '0;
      d_resp_valid <= done && !fetch_q;
      d_resp_err <= state == ERR && !fetch_q;
      d_resp_rdata <= state == ACCESS && !fetch_q && !we_q ? ext : '0;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench with a behavioural RAM behind the arbiter
module tb_ram_arbiter;
  logic        clk = 0, rst = 1;
  logic        i_req_valid = 0, i_req_ready, i_resp_valid, i_resp_err;
  logic [31:0] i_req_addr = 0, i_resp_data;
  logic        d_req_valid = 0, d_req_ready, d_req_we = 0, d_req_unsigned = 0;
  logic [1:0]  d_req_size = 2;
  logic [31:0] d_req_addr = 0, d_req_wdata = 0, d_resp_rdata;
  logic        d_resp_valid, d_resp_err, ram_we;
  logic [31:0] ram_addr, ram_data_in, ram_data_out;
  logic [31:0] mem [1024];
  typedef struct {logic [31:0] data; logic err; int hs; int lat;} exp_t;
  exp_t dq[$], iq[$];
  int cyc = 0, we_cnt = 0, dresp_cnt = 0, n_chk = 0, n_fail = 0;

  ram_arbiter #(.MEM_SIZE(4096)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
    .d_req_wdata(d_req_wdata), .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .d_resp_err(d_resp_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;
  assign ram_data_out = mem[ram_addr[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr[11:2]] <= ram_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ram_we) we_cnt++;
    if (d_resp_valid) begin
      dresp_cnt++;
      if (dq.size() == 0) chk("d_spurious", 32'(dq.size()), 1);
      else begin
        e = dq.pop_front();
        chk("d_rdata", d_resp_rdata, e.data);
        chk("d_err", 32'(d_resp_err), 32'(e.err));
        chk("d_lat", 32'(cyc - e.hs), 32'(e.lat));
      end
    end
    if (i_resp_valid) begin
      if (iq.size() == 0) chk("i_spurious", 32'(iq.size()), 1);
      else begin
        e = iq.pop_front();
        chk("i_data", i_resp_data, e.data);
        chk("i_err", 32'(i_resp_err), 32'(e.err));
        chk("i_lat", 32'(cyc - e.hs), 32'(e.lat));
      end
    end
  end

  task automatic req_d(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat,
                       input bit push);
    bit got = 0;
    @(posedge clk); #1;
    d_req_addr = a; d_req_we = we; d_req_size = sz; d_req_unsigned = u; d_req_wdata = wd;
    d_req_valid = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (d_req_ready) begin
        got = 1;
        if (push) dq.push_back('{er, ee, cyc, lat});
      end
    end
    chk("d_handshake", 32'(got), 1);
    @(posedge clk); #1;
    d_req_valid = 0;
  endtask

  task automatic req_i(input logic [31:0] a, input logic [31:0] er, input logic ee);
    bit got = 0;
    @(posedge clk); #1;
    i_req_addr = a; i_req_valid = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (i_req_ready) begin
        got = 1;
        iq.push_back('{er, ee, cyc, 2});
      end
    end
    chk("i_handshake", 32'(got), 1);
    @(posedge clk); #1;
    i_req_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (dq.size() != 0 || iq.size() != 0); k++) @(negedge clk);
    chk("drain", 32'(dq.size() + iq.size()), 0);
  endtask

  initial begin
    int w0, r0, n;
    int grants[4];
    for (int k = 0; k < 1024; k++) mem[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_i_ready", 32'(i_req_ready), 0);
    chk("rst_d_ready", 32'(d_req_ready), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_resp", 32'({i_resp_valid, d_resp_valid}), 0);
    chk("rst_ram_addr", ram_addr, 0);
    @(posedge clk); #1; rst = 0;
    w0 = we_cnt;
    req_d(32'h10, 1, 2, 0, 32'hDEADBEEF, 0, 0, 2, 1); drain();
    chk("sw_we_cycles", 32'(we_cnt - w0), 1);
    req_d(32'h10, 0, 2, 0, 0, 32'hDEADBEEF, 0, 2, 1); drain();
    req_d(32'h10, 1, 2, 0, 32'h11223344, 0, 0, 2, 1); drain();
    w0 = we_cnt;
    req_d(32'h13, 1, 0, 0, 32'h000000AA, 0, 0, 3, 1); drain();
    chk("sb_we_cycles", 32'(we_cnt - w0), 1);
    chk("sb_mem", mem[4], 32'hAA223344);
    req_d(32'h13, 0, 0, 0, 0, 32'hFFFFFFAA, 0, 2, 1);
    req_d(32'h13, 0, 0, 1, 0, 32'h000000AA, 0, 2, 1);
    req_d(32'h12, 0, 1, 0, 0, 32'hFFFFAA22, 0, 2, 1);
    req_d(32'h10, 0, 1, 1, 0, 32'h00003344, 0, 2, 1);
    req_d(32'h11, 0, 0, 0, 0, 32'h00000033, 0, 2, 1); drain();
    req_d(32'h10, 1, 1, 0, 32'hCAFE5566, 0, 0, 3, 1); drain();
    chk("sh_mem", mem[4], 32'hAA225566);
    req_i(32'h10, 32'hAA225566, 0); drain();
    w0 = we_cnt;
    req_d(32'h11, 0, 1, 0, 0, 0, 1, 2, 1);
    req_d(32'd4096, 0, 2, 0, 0, 0, 1, 2, 1);
    req_d(32'h10, 0, 3, 0, 0, 0, 1, 2, 1);
    req_d(32'h12, 1, 2, 0, 32'h12345678, 0, 1, 2, 1);
    req_i(32'h2, 0, 1); drain();
    chk("err_no_we", 32'(we_cnt - w0), 0);
    chk("err_mem", mem[4], 32'hAA225566);
    w0 = we_cnt; r0 = dresp_cnt;
    req_d(32'h13, 1, 0, 0, 32'h00000055, 0, 0, 3, 0);
    rst = 1;
    repeat (2) @(posedge clk); #1; rst = 0;
    repeat (4) @(negedge clk);
    chk("rstmid_no_we", 32'(we_cnt - w0), 0);
    chk("rstmid_no_resp", 32'(dresp_cnt - r0), 0);
    chk("rstmid_mem", mem[4], 32'hAA225566);
    req_d(32'h13, 0, 0, 1, 0, 32'h000000AA, 0, 2, 1); drain();
    @(posedge clk); #1;
    rst = 1;
    i_req_addr = 32'h10; d_req_addr = 32'h10; d_req_we = 0; d_req_size = 2; d_req_unsigned = 0;
    i_req_valid = 1; d_req_valid = 1;
    repeat (2) @(posedge clk); #1; rst = 0;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      chk("arb_excl", 32'(i_req_ready & d_req_ready), 0);
      if (i_req_ready) begin grants[n] = 0; n++; iq.push_back('{32'hAA225566, 0, cyc, 2}); end
      else if (d_req_ready) begin grants[n] = 1; n++; dq.push_back('{32'hAA225566, 0, cyc, 2}); end
    end
    @(posedge clk); #1;
    i_req_valid = 0; d_req_valid = 0;
    chk("arb_count", 32'(n), 4);
    for (int k = 0; k < n; k++) chk("arb_grant", 32'(grants[k]), 32'(k % 2));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port byte-addressed RAM between an instruction-fetch requester (read-only) and a data load/store requester.
- Sequences every access with a round-robin grant, and checks bounds and alignment.
- Extracts byte and halfword load data, with sign extension when requested.
- Performs byte and halfword stores as a two-cycle read-modify-write, because the RAM only writes full 32-bit words.

Parameters:
- MEM_SIZE, 4096, RAM size in bytes; must match the attached RAM; multiple of 4.

Ports:
- clk  in  1  clock; RAM write edge.
- rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  32  fetch byte address.
- i_resp_valid  out  1  one-cycle fetch response pulse.
- i_resp_data  out  32  fetched word.
- i_resp_err  out  1  fetch misaligned or out of range.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted.
- d_req_addr  in  32  data byte address.
- d_req_we  in  1  1=store, 0=load.
- d_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_req_unsigned  in  1  zero-extend loads when 1.
- d_req_wdata  in  32  store data in the low lanes.
- d_resp_valid  out  1  one-cycle data response pulse; issued for loads and stores.
- d_resp_rdata  out  32  extended load data; 0 for stores and errors.
- d_resp_err  out  1  access error.
- ram_addr  out  32  to RAM addr; always word-aligned.
- ram_we  out  1  to RAM write enable.
- ram_data_in  out  32  to RAM write data.
- ram_data_out  in  32  from RAM; combinational read.

Behaviour:
- Reset: state IDLE, last_grant=DATA, all outputs 0 (including ready, resp_valid, ram_we).
- States and transitions:
  - IDLE: ready is asserted only to the granted requester. The other requester's ready is 0.
    - On handshake, latch the request and go to ACCESS, RMW_RD or ERR.
  - ACCESS: ram_addr = {addr[31:2],2'b00}.
    - Load/fetch: capture the lane-extracted ram_data_out.
    - Word store: ram_we=1, ram_data_in=wdata.
    - Next state IDLE; the response pulses in the following cycle.
  - RMW_RD: ram_addr = aligned address; capture ram_data_out into the merge register; next state RMW_WR.
  - RMW_WR: ram_we=1, ram_data_in = merge register with lanes replaced by wdata; next state IDLE, response next cycle.
  - ERR: no RAM access (ram_we=0); next state IDLE; response next cycle with err=1, rdata=0.
- Arbitration:
  - Decided combinationally in IDLE.
  - Both valid: grant the requester opposite last_grant.
  - Single valid: grant it.
  - last_grant updates on each handshake.
  - Fetch therefore wins the first simultaneous request after reset.
- Latency, counted from the handshake in cycle N:
  - Loads, fetches, word stores and errors: response at N+2.
  - Sub-word stores: response at N+3.
  - Next handshake possible at N+2 (or N+3 for sub-word stores), in the cycle the response is shown.
  - Responses cannot be back-pressured.
- Error conditions, all routed to ERR:
  - addr >= MEM_SIZE.
  - size=11.
  - half with addr[0]=1.
  - word or fetch with addr[1:0]!=0.
- Lanes:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Loads are sign-extended unless d_req_unsigned=1.
- Fetch ignores the d_* size and sign fields and always reads a word.
- Requests arriving outside IDLE wait; valid must stay high until ready is seen.
- Reset mid-operation:
  - Any pending RMW write is abandoned (ram_we=0 in the reset cycle).
  - No response is emitted.
  - The in-flight request is dropped and the requester must re-issue.

Decomposition:
- Package ram_arbiter_pkg holds:
  - size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_ILL).
  - state_e (IDLE, ACCESS, RMW_RD, RMW_WR, ERR).
  - grant_e (FETCH, DATA).
- Sub-module ram_lane_unit is purely combinational:
  - extract/sign-extend: word, lane, size, unsigned -> rdata.
  - merge: old word, wdata, lane, size -> new word.
- The arbiter FSM and bounds checks stay in the top module.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load 0x10 -> ram_we for exactly one cycle; load d_resp_rdata=0xDEADBEEF at handshake+2, err=0.
- Byte store 0xAA at 0x13 over word 0x11223344 -> one RMW_RD cycle, then one write of 0xAA223344; response at handshake+3.
- Signed byte load at 0x13 of 0xAA223344 -> rdata=0xFFFFFFAA. Unsigned load -> 0x000000AA. Signed half load at 0x12 -> 0xFFFFAA22.
- i_req_valid and d_req_valid held high from reset -> grants alternate fetch, data, fetch, data.
- Error cases -> err=1 and rdata=0 at handshake+2, with ram_we never asserted:
  - half load at 0x11;
  - fetch at 0x2;
  - load at MEM_SIZE;
  - size=11.
- rst asserted during RMW_RD of a byte store -> no ram_we, no d_resp_valid, state IDLE; the RAM word is unchanged when read back.
